// File: rtl/enq_arb_pkg.sv
// Shared constants and types for the two-requester round-robin enq arbiter.
package enq_arb_pkg;

  localparam int unsigned ENQ_ARB_WIDTH_DEF = 128;
  localparam int unsigned ENQ_ARB_CNT_W_DEF = 16;

  typedef enum logic {
    ARB_IDX_IN  = 1'b0,
    ARB_IDX_FWD = 1'b1
  } arb_idx_e;

endpackage

// File: rtl/arb_hold_slot.sv
// One-entry holding slot; ready is asserted when empty or when drained this cycle.
module arb_hold_slot
  import enq_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ENQ_ARB_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enq_i,
  input  logic             deq_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             rdy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Enqueue takes precedence so a same-cycle drain and refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (enq_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (deq_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rdy_o   = !valid_q | deq_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/enq_rr_arbiter.sv
// Round-robin merge of the primary and forwarding enq streams onto one out_enq port.
// Optional saturating grant counters are enabled with `define ENQ_ARB_COUNT_EN.
module enq_rr_arbiter
  import enq_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ENQ_ARB_WIDTH_DEF
`ifdef ENQ_ARB_COUNT_EN
  , parameter int unsigned CNT_W = ENQ_ARB_CNT_W_DEF
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             forward_enq__ENA,
  input  logic [WIDTH-1:0] forward_enq_v,
  output logic             forward_enq__RDY,
  output logic             out_enq__ENA,
  output logic [WIDTH-1:0] out_enq_v,
  input  logic             out_enq__RDY
`ifdef ENQ_ARB_COUNT_EN
  , input  logic             cnt_clear__ENA
  , output logic [CNT_W-1:0] grant_count_in
  , output logic [CNT_W-1:0] grant_count_fwd
`endif
);

  logic             valid_in, valid_fwd;
  logic [WIDTH-1:0] data_in, data_fwd;
  logic             gnt_in, gnt_fwd, deq_in, deq_fwd, xfer;
  arb_idx_e         last_q, last_d;

  arb_hold_slot #(.WIDTH(WIDTH)) u_slot_in (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .enq_i   (in_enq__ENA),
    .deq_i   (deq_in),
    .data_i  (in_enq_v),
    .rdy_o   (in_enq__RDY),
    .valid_o (valid_in),
    .data_o  (data_in)
  );

  arb_hold_slot #(.WIDTH(WIDTH)) u_slot_fwd (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .enq_i   (forward_enq__ENA),
    .deq_i   (deq_fwd),
    .data_i  (forward_enq_v),
    .rdy_o   (forward_enq__RDY),
    .valid_o (valid_fwd),
    .data_o  (data_fwd)
  );

  // Forward wins when it is alone or when both are full and primary went last.
  always_comb begin
    gnt_fwd   = valid_fwd & (!valid_in | (last_q == ARB_IDX_IN));
    gnt_in    = valid_in & !gnt_fwd;
    xfer      = out_enq__RDY & (valid_in | valid_fwd);
    deq_in    = gnt_in & out_enq__RDY;
    deq_fwd   = gnt_fwd & out_enq__RDY;
    out_enq_v = '0;
    if (gnt_in) begin
      out_enq_v = data_in;
    end else if (gnt_fwd) begin
      out_enq_v = data_fwd;
    end
    last_d = last_q;
    if (xfer) begin
      last_d = gnt_fwd ? ARB_IDX_FWD : ARB_IDX_IN;
    end
  end

  assign out_enq__ENA = xfer;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q <= ARB_IDX_FWD;
    end else begin
      last_q <= last_d;
    end
  end

`ifdef ENQ_ARB_COUNT_EN
  logic [CNT_W-1:0] cnt_in_q, cnt_in_d, cnt_fwd_q, cnt_fwd_d;

  always_comb begin
    cnt_in_d  = cnt_in_q;
    cnt_fwd_d = cnt_fwd_q;
    if (cnt_clear__ENA) begin
      cnt_in_d  = '0;
      cnt_fwd_d = '0;
    end else begin
      if (deq_in && (cnt_in_q != '1)) begin
        cnt_in_d = cnt_in_q + 1'b1;
      end
      if (deq_fwd && (cnt_fwd_q != '1)) begin
        cnt_fwd_d = cnt_fwd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_in_q  <= '0;
      cnt_fwd_q <= '0;
    end else begin
      cnt_in_q  <= cnt_in_d;
      cnt_fwd_q <= cnt_fwd_d;
    end
  end

  assign grant_count_in  = cnt_in_q;
  assign grant_count_fwd = cnt_fwd_q;
`endif

endmodule

// File: tb/tb_enq_rr_arbiter.sv
// Directed vector bench for enq_rr_arbiter; counter checks run when ENQ_ARB_COUNT_EN is defined.
module tb_enq_rr_arbiter;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_ena = 1'b0, fwd_ena = 1'b0, out_rdy = 1'b0;
  logic [W-1:0] in_v = '0, fwd_v = '0;
  logic         in_rdy, fwd_rdy, out_ena;
  logic [W-1:0] out_v;
`ifdef ENQ_ARB_COUNT_EN
  logic         cnt_clr = 1'b0;
  logic [3:0]   cnt_in, cnt_fwd;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enq_rr_arbiter #(
    .WIDTH (W)
`ifdef ENQ_ARB_COUNT_EN
    , .CNT_W (4)
`endif
  ) dut (
    .CLK              (clk),
    .nRST             (rst_n),
    .in_enq__ENA      (in_ena),
    .in_enq_v         (in_v),
    .in_enq__RDY      (in_rdy),
    .forward_enq__ENA (fwd_ena),
    .forward_enq_v    (fwd_v),
    .forward_enq__RDY (fwd_rdy),
    .out_enq__ENA     (out_ena),
    .out_enq_v        (out_v),
    .out_enq__RDY     (out_rdy)
`ifdef ENQ_ARB_COUNT_EN
    , .cnt_clear__ENA  (cnt_clr)
    , .grant_count_in  (cnt_in)
    , .grant_count_fwd (cnt_fwd)
`endif
  );

  typedef struct {
    logic         rst;
    logic         ie;
    logic [W-1:0] iv;
    logic         fe;
    logic [W-1:0] fv;
    logic         ordy;
    logic         e_ena;
    logic [W-1:0] e_v;
    logic         e_ir;
    logic         e_fr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ie, input logic [W-1:0] iv,
                     input logic fe, input logic [W-1:0] fv, input logic ordy,
                     input logic e_ena, input logic [W-1:0] e_v,
                     input logic e_ir, input logic e_fr);
    vec_t v;
    v = '{rst, ie, iv, fe, fv, ordy, e_ena, e_v, e_ir, e_fr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_ena  = 1'b0;
    fwd_ena = 1'b0;
    in_v    = '0;
    fwd_v   = '0;
    out_rdy = 1'b0;
`ifdef ENQ_ARB_COUNT_EN
    cnt_clr = 1'b0;
`endif
  endtask

  // Called just after a negedge; the reset pulse ends well before the next posedge.
  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Single stream 0x1..0x8
    add(1, 1, 16'h1, 0, 0, 1, 0, 0, 1, 1);
    for (int k = 1; k <= 7; k++) add(0, 1, W'(k + 1), 0, 0, 1, 1, W'(k), 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 16'h8, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    // Contention A0..A3 / B0..B3
    add(1, 1, 16'hA0, 1, 16'hB0, 1, 0, 0,      1, 1);
    add(0, 1, 16'hA1, 0, 0,      1, 1, 16'hA0, 1, 0);
    add(0, 0, 0,      1, 16'hB1, 1, 1, 16'hB0, 0, 1);
    add(0, 1, 16'hA2, 0, 0,      1, 1, 16'hA1, 1, 0);
    add(0, 0, 0,      1, 16'hB2, 1, 1, 16'hB1, 0, 1);
    add(0, 1, 16'hA3, 0, 0,      1, 1, 16'hA2, 1, 0);
    add(0, 0, 0,      1, 16'hB3, 1, 1, 16'hB2, 0, 1);
    add(0, 0, 0,      0, 0,      1, 1, 16'hA3, 1, 0);
    add(0, 0, 0,      0, 0,      1, 1, 16'hB3, 1, 1);
    add(0, 0, 0,      0, 0,      1, 0, 0,      1, 1);
    // Backpressure for 5 cycles with both slots full
    add(1, 1, 16'h11, 1, 16'h22, 1, 0, 0, 1, 1);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 0, 16'h11, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 16'h11, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 16'h22, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      1, 1);
    // Forward gap during contention
    add(1, 1, 16'h31, 1, 16'h41, 1, 0, 0,      1, 1);
    add(0, 1, 16'h32, 0, 0,      1, 1, 16'h31, 1, 0);
    add(0, 0, 0,      0, 0,      1, 1, 16'h41, 0, 1);
    add(0, 1, 16'h33, 1, 16'h42, 1, 1, 16'h32, 1, 1);
    add(0, 0, 0,      0, 0,      1, 1, 16'h42, 0, 1);
    add(0, 0, 0,      0, 0,      1, 1, 16'h33, 1, 1);
    add(0, 0, 0,      0, 0,      1, 0, 0,      1, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) pulse_reset();
      in_ena  = vecs[i].ie;
      in_v    = vecs[i].iv;
      fwd_ena = vecs[i].fe;
      fwd_v   = vecs[i].fv;
      out_rdy = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d_out_ena", i), 32'(out_ena), 32'(vecs[i].e_ena));
      chk($sformatf("row%0d_out_v", i),   32'(out_v),   32'(vecs[i].e_v));
      chk($sformatf("row%0d_in_rdy", i),  32'(in_rdy),  32'(vecs[i].e_ir));
      chk($sformatf("row%0d_fwd_rdy", i), 32'(fwd_rdy), 32'(vecs[i].e_fr));
    end

    // Asynchronous reset while both slots are held
    @(negedge clk);
    idle_inputs();
    in_ena = 1'b1; in_v = 16'h61; fwd_ena = 1'b1; fwd_v = 16'h71;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("hold_out_ena", 32'(out_ena), 32'd0);
    chk("hold_in_rdy",  32'(in_rdy),  32'd0);
    chk("hold_fwd_rdy", 32'(fwd_rdy), 32'd0);
    out_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_ena", 32'(out_ena), 32'd0);
    chk("rst_out_v",   32'(out_v),   32'd0);
    chk("rst_in_rdy",  32'(in_rdy),  32'd1);
    chk("rst_fwd_rdy", 32'(fwd_rdy), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_ena", k), 32'(out_ena), 32'd0);
      chk($sformatf("post_rst%0d_rdy", k), 32'({in_rdy, fwd_rdy}), 32'd3);
    end

`ifdef ENQ_ARB_COUNT_EN
    // Counter saturation at 15 and clear-over-increment
    @(negedge clk);
    pulse_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_ena = 1'b1;
      in_v   = W'(k + 1);
      @(negedge clk);
    end
    in_ena = 1'b0; fwd_ena = 1'b1; fwd_v = 16'h55;
    @(negedge clk);
    fwd_ena = 1'b0;
    #1;
    chk("cnt_in_sat", 32'(cnt_in), 32'd15);
    chk("cnt_fwd_zero", 32'(cnt_fwd), 32'd0);
    @(negedge clk);
    #1;
    chk("cnt_fwd_one", 32'(cnt_fwd), 32'd1);
    in_ena = 1'b1; in_v = 16'h77;
    @(negedge clk);
    in_ena = 1'b0; cnt_clr = 1'b1;
    #1;
    chk("clr_xfer_ena", 32'(out_ena), 32'd1);
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr_cnt_in",  32'(cnt_in),  32'd0);
    chk("clr_cnt_fwd", 32'(cnt_fwd), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
